// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 key-event receiver.
package ps2_pkg;

    typedef struct packed {
        logic       ext;
        logic       make;
        logic [7:0] code;
    } ps2_evt_t;

    localparam logic [7:0] PS2_EXT    = 8'hE0;
    localparam logic [7:0] PS2_BRK    = 8'hF0;
    localparam logic [7:0] PS2_PAUSE  = 8'hE1;
    localparam logic [7:0] PS2_BAT    = 8'hAA;
    localparam logic [7:0] PS2_ACK    = 8'hFA;
    localparam logic [7:0] PS2_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_RESEND = 8'hFE;

    localparam logic [2:0] PAUSE_TAIL = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } frame_state_t;

endpackage

// File: rtl/ps2_frame_rx.sv
// PS/2 line front end: synchroniser, clock glitch filter, falling-edge detect,
// 11-bit frame FSM with odd-parity / stop / timeout checking.
//   state     | meaning
//   ST_IDLE   | waiting for a start bit (data=0 at a falling edge)
//   ST_DATA   | shifting in 8 data bits, LSB first
//   ST_PARITY | capturing the odd-parity bit
//   ST_STOP   | checking the stop bit, then reporting good/bad frame
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_LEN    = 8,
    parameter int FRAME_TIMEOUT = 20000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       frame_err
);

    localparam int FW = $clog2(FILTER_LEN) + 1;
    localparam int TW = $clog2(FRAME_TIMEOUT + 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_data_sync;
    logic [FW-1:0]          r_filt_cnt;
    logic                   r_filt;
    logic                   r_filt_d;
    logic [TW-1:0]          r_tcnt;
    logic [2:0]             r_bit_cnt;
    logic [7:0]             r_shift;
    logic                   r_par_ok;
    frame_state_t           r_state;
    frame_state_t           w_state_nxt;
    logic                   w_clk_s;
    logic                   w_data_s;
    logic                   w_e;
    logic                   w_tout;
    logic                   w_good;
    logic                   w_bad;

    assign w_clk_s  = r_clk_sync[SYNC_STAGES-1];
    assign w_data_s = r_data_sync[SYNC_STAGES-1];
    assign w_e      = r_filt_d & ~r_filt;
    assign w_tout   = (r_state != ST_IDLE) && (r_tcnt == TW'(FRAME_TIMEOUT));

    // Filtered clock follows the synced clock only after FILTER_LEN agreeing samples.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_clk_sync  <= '1;
            r_data_sync <= '1;
            r_filt_cnt  <= '0;
            r_filt      <= 1'b1;
            r_filt_d    <= 1'b1;
        end else begin
            r_clk_sync  <= {r_clk_sync[SYNC_STAGES-2:0], ps2_clk};
            r_data_sync <= {r_data_sync[SYNC_STAGES-2:0], ps2_data};
            r_filt_d    <= r_filt;
            if (w_clk_s == r_filt) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_filt     <= w_clk_s;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good      = 1'b0;
        w_bad       = 1'b0;
        if (w_e) begin
            case (r_state)
                ST_IDLE:   if (!w_data_s) w_state_nxt = ST_DATA;
                ST_DATA:   if (r_bit_cnt == 3'd7) w_state_nxt = ST_PARITY;
                ST_PARITY: w_state_nxt = ST_STOP;
                ST_STOP: begin
                    w_state_nxt = ST_IDLE;
                    w_good      = w_data_s & r_par_ok;
                    w_bad       = ~(w_data_s & r_par_ok);
                end
                default:   w_state_nxt = ST_IDLE;
            endcase
        end else if (w_tout) begin
            w_state_nxt = ST_IDLE;
            w_bad       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tcnt     <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_ok   <= 1'b0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= w_good;
            frame_err  <= w_bad;
            if (w_e || r_state == ST_IDLE) r_tcnt <= '0;
            else                           r_tcnt <= r_tcnt + 1'b1;
            if (w_e) begin
                case (r_state)
                    ST_IDLE: r_bit_cnt <= '0;
                    ST_DATA: begin
                        r_shift   <= {w_data_s, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 1'b1;
                    end
                    ST_PARITY: r_par_ok <= w_data_s ^ (^r_shift);
                    default: ;
                endcase
            end
        end
    end

    assign byte_data = r_shift;

endmodule

// File: rtl/ps2_key_event_rx.sv
// PS/2 keyboard receiver: frame front end, E0/F0/E1 prefix decoder and a
// key-event FIFO with valid/ready handshake plus legacy current_* outputs.
module ps2_key_event_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_LEN    = 8,
    parameter int FRAME_TIMEOUT = 20000,
    parameter int FIFO_DEPTH    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       evt_valid,
    input  logic       evt_ready,
    output logic [9:0] evt_data,
    output logic [7:0] current_scan_code,
    output logic       current_make_break,
    output logic       current_extended,
    output logic       frame_err,
    output logic [7:0] err_count,
    output logic       ovf,
    input  logic       ovf_clr
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic           w_byte_valid;
    logic [7:0]     w_byte;
    logic           r_ext_pend;
    logic           r_brk_pend;
    logic [2:0]     r_skip;
    logic           r_push;
    ps2_evt_t       r_evt;
    ps2_evt_t       r_mem [FIFO_DEPTH];
    logic [AW-1:0]  r_wr_ptr;
    logic [AW-1:0]  r_rd_ptr;
    logic [AW:0]    r_cnt;
    logic           w_full;
    logic           w_pop;
    logic           w_wr;
    logic           w_drop;

    ps2_frame_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_LEN    (FILTER_LEN),
        .FRAME_TIMEOUT (FRAME_TIMEOUT)
    ) u_frame_rx (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_data   (ps2_data),
        .byte_valid (w_byte_valid),
        .byte_data  (w_byte),
        .frame_err  (frame_err)
    );

    // A bad frame or timeout also abandons any pending prefix or pause tail.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ext_pend <= 1'b0;
            r_brk_pend <= 1'b0;
            r_skip     <= '0;
            r_push     <= 1'b0;
            r_evt      <= '0;
            err_count  <= '0;
        end else begin
            r_push <= 1'b0;
            if (frame_err) begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
                r_skip     <= '0;
                if (err_count != 8'hFF) err_count <= err_count + 1'b1;
            end else if (w_byte_valid) begin
                if (r_skip != 3'd0) begin
                    r_skip <= r_skip - 1'b1;
                end else begin
                    case (w_byte)
                        PS2_EXT:   r_ext_pend <= 1'b1;
                        PS2_BRK:   r_brk_pend <= 1'b1;
                        PS2_PAUSE: r_skip     <= PAUSE_TAIL;
                        PS2_BAT, PS2_ACK, PS2_ECHO, PS2_RESEND, 8'h00, 8'hFF: ;
                        default: begin
                            r_push     <= 1'b1;
                            r_evt      <= '{ext: r_ext_pend, make: ~r_brk_pend, code: w_byte};
                            r_ext_pend <= 1'b0;
                            r_brk_pend <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    assign current_scan_code  = r_evt.code;
    assign current_make_break = r_evt.make;
    assign current_extended   = r_evt.ext;

    assign evt_valid = (r_cnt != '0);
    assign w_full    = (r_cnt == (AW+1)'(FIFO_DEPTH));
    assign w_pop     = evt_valid & evt_ready;
    assign w_wr      = r_push & (~w_full | w_pop);
    assign w_drop    = r_push & w_full & ~w_pop;
    assign evt_data  = evt_valid ? r_mem[r_rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= r_evt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
            ovf      <= 1'b0;
        end else begin
            if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_cnt <= r_cnt + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_pop};
            if (w_drop)       ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_key_event_rx.sv
// Directed bench for ps2_key_event_rx: table of frames with expected events,
// plus hand-written timeout, overflow, glitch and reset sequences.
module tb_ps2_key_event_rx;

    localparam int HALF = 20;

    logic       clk       = 1'b0;
    logic       rst       = 1'b0;
    logic       ps2_clk   = 1'b1;
    logic       ps2_data  = 1'b1;
    logic       evt_ready = 1'b0;
    logic       ovf_clr   = 1'b0;
    logic       evt_valid;
    logic [9:0] evt_data;
    logic [7:0] current_scan_code;
    logic       current_make_break;
    logic       current_extended;
    logic       frame_err;
    logic [7:0] err_count;
    logic       ovf;

    int         n_checks   = 0;
    int         n_pass     = 0;
    int         err_pulses = 0;
    logic [9:0] q [$];

    typedef struct {
        logic [7:0] b;
        bit         bad_par;
        bit         has_evt;
        logic [9:0] evt;
        bit         err;
    } vec_t;
    vec_t vecs [$];

    ps2_key_event_rx dut (
        .clk                (clk),
        .rst                (rst),
        .ps2_clk            (ps2_clk),
        .ps2_data           (ps2_data),
        .evt_valid          (evt_valid),
        .evt_ready          (evt_ready),
        .evt_data           (evt_data),
        .current_scan_code  (current_scan_code),
        .current_make_break (current_make_break),
        .current_extended   (current_extended),
        .frame_err          (frame_err),
        .err_count          (err_count),
        .ovf                (ovf),
        .ovf_clr            (ovf_clr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (evt_valid && evt_ready) q.push_back(evt_data);
        if (frame_err) err_pulses++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            tick(6);
            ps2_clk = 1'b0;
            tick(3);
            ps2_clk = 1'b1;
            tick(HALF - 9);
        end else begin
            tick(HALF);
        end
        ps2_clk = 1'b0;
        tick(HALF);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits, input int glitch_bit);
        logic [10:0] bits;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = b[i];
        bits[9]  = (~^b) ^ bad_par;
        bits[10] = 1'b1;
        for (int i = 0; i < nbits; i++) send_bit(bits[i], i == glitch_bit);
        ps2_data = 1'b1;
        tick(2 * HALF);
    endtask

    task automatic add_vec(input logic [7:0] b, input bit bad, input bit has, input logic [9:0] evt, input bit err);
        vec_t v;
        v.b = b; v.bad_par = bad; v.has_evt = has; v.evt = evt; v.err = err;
        vecs.push_back(v);
    endtask

    initial begin
        logic [9:0] got;
        int         e0;
        logic [7:0] codes [9];

        // event layout is {ext, make, code}
        add_vec(8'h1C, 0, 1, 10'h11C, 0);
        add_vec(8'hF0, 0, 0, 10'h000, 0);
        add_vec(8'h1C, 0, 1, 10'h01C, 0);
        add_vec(8'hE0, 0, 0, 10'h000, 0);
        add_vec(8'hF0, 0, 0, 10'h000, 0);
        add_vec(8'h75, 0, 1, 10'h275, 0);
        add_vec(8'hE0, 0, 0, 10'h000, 0);
        add_vec(8'h1C, 1, 0, 10'h000, 1);
        add_vec(8'h75, 0, 1, 10'h175, 0);
        add_vec(8'hE0, 0, 0, 10'h000, 0);
        add_vec(8'hAA, 0, 0, 10'h000, 0);
        add_vec(8'h75, 0, 1, 10'h375, 0);
        add_vec(8'hE1, 0, 0, 10'h000, 0);
        add_vec(8'h14, 0, 0, 10'h000, 0);
        add_vec(8'h77, 0, 0, 10'h000, 0);
        add_vec(8'hE1, 0, 0, 10'h000, 0);
        add_vec(8'hF0, 0, 0, 10'h000, 0);
        add_vec(8'h14, 0, 0, 10'h000, 0);
        add_vec(8'hF0, 0, 0, 10'h000, 0);
        add_vec(8'h77, 0, 0, 10'h000, 0);
        add_vec(8'h1C, 0, 1, 10'h11C, 0);

        tick(3);
        check("rst_evt_valid", evt_valid, 0);
        check("rst_evt_data", evt_data, 0);
        check("rst_err_count", err_count, 0);
        check("rst_ovf", ovf, 0);
        check("rst_current", {current_extended, current_make_break, current_scan_code}, 0);
        rst = 1'b1;
        evt_ready = 1'b1;
        tick(5);

        for (int i = 0; i < vecs.size(); i++) begin
            q.delete();
            e0 = err_pulses;
            send_frame(vecs[i].b, vecs[i].bad_par, 11, -1);
            tick(10);
            check($sformatf("v%0d_evt_count", i), q.size(), vecs[i].has_evt ? 1 : 0);
            check($sformatf("v%0d_err_pulses", i), err_pulses - e0, vecs[i].err ? 1 : 0);
            if (vecs[i].has_evt) begin
                got = (q.size() > 0) ? q[0] : 10'bx;
                check($sformatf("v%0d_evt_data", i), got, vecs[i].evt);
                check($sformatf("v%0d_current", i),
                      {current_extended, current_make_break, current_scan_code}, vecs[i].evt);
            end
        end
        check("table_err_count", err_count, 1);
        check("table_ovf", ovf, 0);

        // timeout after a truncated frame
        q.delete();
        e0 = err_pulses;
        send_frame(8'h00, 0, 4, -1);
        tick(19900);
        check("tout_not_yet", err_pulses - e0, 0);
        tick(200);
        check("tout_pulse", err_pulses - e0, 1);
        check("tout_err_count", err_count, 2);
        check("tout_no_evt", q.size(), 0);
        send_frame(8'h1C, 0, 11, -1);
        tick(10);
        got = (q.size() > 0) ? q[0] : 10'bx;
        check("tout_recover_evt", got, 10'h11C);
        check("tout_recover_err", err_pulses - e0, 1);

        // overflow: 9 events into an 8-entry FIFO
        codes[0] = 8'h15; codes[1] = 8'h1D; codes[2] = 8'h24; codes[3] = 8'h2D; codes[4] = 8'h2C;
        codes[5] = 8'h35; codes[6] = 8'h3C; codes[7] = 8'h43; codes[8] = 8'h44;
        evt_ready = 1'b0;
        q.delete();
        for (int i = 0; i < 9; i++) send_frame(codes[i], 0, 11, -1);
        tick(5);
        check("ovf_set", ovf, 1);
        check("ovf_valid", evt_valid, 1);
        check("ovf_head", evt_data, {2'b01, codes[0]});
        check("ovf_current_dropped", current_scan_code, codes[8]);
        evt_ready = 1'b1;
        tick(20);
        check("drain_count", q.size(), 8);
        for (int i = 0; i < 8; i++) begin
            got = (q.size() > i) ? q[i] : 10'bx;
            check($sformatf("drain_%0d", i), got, {2'b01, codes[i]});
        end
        check("drain_empty", evt_valid, 0);
        check("ovf_sticky", ovf, 1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        tick(1);
        check("ovf_cleared", ovf, 0);

        // glitch on ps2_clk mid-byte, then reset part way into the next frame
        evt_ready = 1'b0;
        e0 = err_pulses;
        send_frame(8'h1C, 0, 11, 3);
        tick(5);
        check("glitch_valid", evt_valid, 1);
        check("glitch_evt", evt_data, 10'h11C);
        check("glitch_no_err", err_pulses - e0, 0);
        send_frame(8'h5A, 0, 4, -1);
        rst = 1'b0;
        tick(3);
        check("rst2_evt_valid", evt_valid, 0);
        check("rst2_evt_data", evt_data, 0);
        check("rst2_current", {current_extended, current_make_break, current_scan_code}, 0);
        check("rst2_err_count", err_count, 0);
        check("rst2_flags", {ovf, frame_err}, 0);
        rst = 1'b1;
        tick(5);
        evt_ready = 1'b1;
        q.delete();
        e0 = err_pulses;
        send_frame(8'h1C, 0, 11, -1);
        tick(10);
        got = (q.size() > 0) ? q[0] : 10'bx;
        check("post_rst_evt", got, 10'h11C);
        check("post_rst_count", q.size(), 1);
        check("post_rst_err", err_pulses - e0, 0);
        check("post_rst_err_count", err_count, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
